// File: rtl/vend_credit_ctrl.sv
// Credit-accumulating vending controller: takes 5/10-unit coins, accepts a priced
// selection, runs the dispenser req/ack handshake and refunds change as 5-unit pulses.
module vend_credit_ctrl #(
  parameter int unsigned MAX_CREDIT = 30,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin_in,
  input  logic       sel_valid,
  input  logic [1:0] sel,
  input  logic       cancel,
  input  logic       vend_ack,
  output logic       vend_req,
  output logic [1:0] vend_item,
  output logic       chg_pulse,
  output logic [5:0] credit,
  output logic       coin_reject,
  output logic       short_credit,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  localparam int unsigned TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [6:0]  MAX_C    = 7'(MAX_CREDIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [5:0]  COIN_UNIT = 6'd5;

  state_t        state;
  logic [TW-1:0] tmo_cnt;

  logic [5:0] coin_val;
  logic       coin_present;
  logic       coin_fits;
  logic [5:0] price;
  logic       price_ok;
  logic       tmo_expired;

  always_comb begin
    coin_val     = '0;
    coin_present = 1'b0;
    case (coin_in)
      2'b01: begin
        coin_val     = 6'd5;
        coin_present = 1'b1;
      end
      2'b10: begin
        coin_val     = 6'd10;
        coin_present = 1'b1;
      end
      default: begin
        coin_val     = '0;
        coin_present = 1'b0;
      end
    endcase
    coin_fits = ({1'b0, credit} + {1'b0, coin_val}) <= MAX_C;

    case (sel)
      2'd0:    price = 6'd5;
      2'd1:    price = 6'd10;
      2'd2:    price = 6'd15;
      default: price = 6'd20;
    endcase
    price_ok    = credit >= price;
    tmo_expired = tmo_cnt == TMO_LAST;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      credit       <= '0;
      vend_req     <= 1'b0;
      vend_item    <= '0;
      chg_pulse    <= 1'b0;
      coin_reject  <= 1'b0;
      short_credit <= 1'b0;
      busy         <= 1'b0;
    end else begin
      coin_reject  <= 1'b0;
      short_credit <= 1'b0;
      chg_pulse    <= 1'b0;

      case (state)
        IDLE: begin
          if (coin_present) begin
            if (coin_fits) begin
              credit  <= credit + coin_val;
              tmo_cnt <= '0;
              state   <= CREDIT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
          if (sel_valid) short_credit <= 1'b1;
        end

        // Priority cancel > coin > selection; every cycle without an accepted
        // coin or selection advances the inactivity counter.
        CREDIT: begin
          if (cancel) begin
            coin_reject <= coin_present;
            tmo_cnt     <= '0;
            chg_pulse   <= 1'b1;
            credit      <= credit - COIN_UNIT;
            busy        <= 1'b1;
            state       <= CHANGE;
          end else if (coin_present && coin_fits) begin
            credit  <= credit + coin_val;
            tmo_cnt <= '0;
          end else if (sel_valid && !coin_present && price_ok) begin
            credit    <= credit - price;
            vend_item <= sel;
            vend_req  <= 1'b1;
            busy      <= 1'b1;
            tmo_cnt   <= '0;
            state     <= VEND;
          end else begin
            if (coin_present) coin_reject <= 1'b1;
            else if (sel_valid) short_credit <= 1'b1;
            if (tmo_expired) begin
              tmo_cnt   <= '0;
              chg_pulse <= 1'b1;
              credit    <= credit - COIN_UNIT;
              busy      <= 1'b1;
              state     <= CHANGE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
        end

        VEND: begin
          coin_reject <= coin_present;
          if (vend_ack) begin
            vend_req  <= 1'b0;
            vend_item <= '0;
            if (credit != '0) begin
              chg_pulse <= 1'b1;
              credit    <= credit - COIN_UNIT;
              state     <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        // Credit drops together with each visible pulse, so the low cycle after
        // the pulse that reaches zero is the last CHANGE cycle.
        CHANGE: begin
          coin_reject <= coin_present;
          if (chg_pulse) begin
            if (credit == '0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            chg_pulse <= 1'b1;
            credit    <= credit - COIN_UNIT;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Directed table-driven bench for vend_credit_ctrl, plus a timeout sequence on a
// second instance built with a short inactivity limit.
module tb_vend_credit_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, sel_valid, cancel, vend_ack;
  logic [1:0] coin_in, sel;
  logic       vend_req, chg_pulse, coin_reject, short_credit, busy;
  logic [1:0] vend_item;
  logic [5:0] credit;

  vend_credit_ctrl #(.MAX_CREDIT(30), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .sel_valid(sel_valid), .sel(sel),
    .cancel(cancel), .vend_ack(vend_ack), .vend_req(vend_req), .vend_item(vend_item),
    .chg_pulse(chg_pulse), .credit(credit), .coin_reject(coin_reject),
    .short_credit(short_credit), .busy(busy)
  );

  logic       t_rst, t_sv, t_cancel, t_ack;
  logic [1:0] t_coin, t_sel;
  logic       t_req, t_chg, t_crej, t_short, t_busy;
  logic [1:0] t_item;
  logic [5:0] t_credit;

  vend_credit_ctrl #(.MAX_CREDIT(30), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst(t_rst), .coin_in(t_coin), .sel_valid(t_sv), .sel(t_sel),
    .cancel(t_cancel), .vend_ack(t_ack), .vend_req(t_req), .vend_item(t_item),
    .chg_pulse(t_chg), .credit(t_credit), .coin_reject(t_crej),
    .short_credit(t_short), .busy(t_busy)
  );

  typedef struct {
    logic       rst;
    logic [1:0] coin;
    logic       sv;
    logic [1:0] sel;
    logic       cancel;
    logic       ack;
    logic       req;
    logic [1:0] item;
    logic       chg;
    logic [5:0] credit;
    logic       crej;
    logic       shrt;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic add(input logic r, input logic [1:0] c, input logic s, input logic [1:0] sl,
                     input logic cn, input logic a, input logic rq, input logic [1:0] it,
                     input logic ch, input logic [5:0] cr, input logic cj, input logic sh,
                     input logic b);
    vec_t v;
    v.rst = r; v.coin = c; v.sv = s; v.sel = sl; v.cancel = cn; v.ack = a;
    v.req = rq; v.item = it; v.chg = ch; v.credit = cr; v.crej = cj; v.shrt = sh; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int pulses;
    rst = 1'b1; coin_in = '0; sel_valid = 1'b0; sel = '0; cancel = 1'b0; vend_ack = 1'b0;
    t_rst = 1'b1; t_coin = '0; t_sv = 1'b0; t_sel = '0; t_cancel = 1'b0; t_ack = 1'b0;

    //   rst coin sv sel can ack | req item chg credit crej short busy
    // coin 5 then sel 0, vend, back to IDLE
    add(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0,  5, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 1, 2, 0, 0,  0, 0, 0,  0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0, 0,  0, 0, 0, 0);
    // 10+10+5, sel 1 (price 10), ack, three change pulses
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 10, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 20, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 25, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1, 1, 0, 15, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1,  0, 0, 1, 10, 0, 0, 1);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 10, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1,  5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,  5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    // saturation at 30, then reset clears credit without refund
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 10, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 20, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 25, 0, 0, 0);
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 25, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 30, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0, 30, 1, 0, 0);
    add(0, 3, 0, 0, 0, 0,  0, 0, 0, 30, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    // credit 10, sel 3 short, cancel refunds two pulses
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 10, 0, 0, 0);
    add(0, 0, 1, 3, 0, 0,  0, 0, 0, 10, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0, 10, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0,  0, 0, 1,  5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,  5, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 1,  0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    // cancel with coin; coin with sel drops sel; zero-wait ack with coin in VEND
    add(0, 1, 0, 0, 0, 0,  0, 0, 0,  5, 0, 0, 0);
    add(0, 2, 0, 0, 1, 0,  0, 0, 1,  0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0,  0, 0, 0,  5, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0,  0, 0, 0, 10, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0,  1, 1, 0,  0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1,  0, 0, 0,  0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    // reset during VEND, later ack ignored
    add(0, 2, 0, 0, 0, 0,  0, 0, 0, 10, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0,  1, 0, 0,  5, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; coin_in = vecs[i].coin; sel_valid = vecs[i].sv; sel = vecs[i].sel;
      cancel = vecs[i].cancel; vend_ack = vecs[i].ack;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.vend_req", i),     32'(vend_req),     32'(vecs[i].req));
      chk($sformatf("v%0d.vend_item", i),    32'(vend_item),    32'(vecs[i].item));
      chk($sformatf("v%0d.chg_pulse", i),    32'(chg_pulse),    32'(vecs[i].chg));
      chk($sformatf("v%0d.credit", i),       32'(credit),       32'(vecs[i].credit));
      chk($sformatf("v%0d.coin_reject", i),  32'(coin_reject),  32'(vecs[i].crej));
      chk($sformatf("v%0d.short_credit", i), 32'(short_credit), 32'(vecs[i].shrt));
      chk($sformatf("v%0d.busy", i),         32'(busy),         32'(vecs[i].busy));
    end
    rst = 1'b0; coin_in = '0; sel_valid = 1'b0; cancel = 1'b0; vend_ack = 1'b0;

    // Inactivity refund with TIMEOUT = 4
    t_rst = 1'b1;
    @(posedge clk); #1;
    t_rst = 1'b0; t_coin = 2'b01;
    @(posedge clk); #1;
    t_coin = 2'b00;
    chk("tmo.credit_after_coin", 32'(t_credit), 32'd5);
    chk("tmo.chg_after_coin", 32'(t_chg), 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("tmo.idle%0d.chg", k), 32'(t_chg), 32'd0);
      chk($sformatf("tmo.idle%0d.credit", k), 32'(t_credit), 32'd5);
    end
    @(posedge clk); #1;
    chk("tmo.pulse", 32'(t_chg), 32'd1);
    chk("tmo.credit_refunded", 32'(t_credit), 32'd0);
    chk("tmo.busy", 32'(t_busy), 32'd1);
    @(posedge clk); #1;
    chk("tmo.idle_busy", 32'(t_busy), 32'd0);
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      if (t_chg === 1'b1) pulses++;
      @(posedge clk); #1;
    end
    chk("tmo.no_extra_pulses", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
